// File: rtl/glyph_string_draw_pkg.sv
// Shared state encoding and default geometry for the glyph string renderer.
package glyph_string_draw_pkg;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_IDLE  = 2'd1,
        S_CLEAR = 2'd2,
        S_DRAW  = 2'd3
    } state_t;

    localparam int DEF_GLYPH_W    = 12;
    localparam int DEF_GLYPH_H    = 12;
    localparam int DEF_NUM_GLYPHS = 3;
    localparam int DEF_SCREEN_W   = 160;
    localparam int DEF_SCREEN_H   = 120;
    localparam int DEF_COLOUR_W   = 3;

    // Coordinate output widths, and the guard bits used for unclipped addresses.
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int ADDR_PAD = 2;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/glyph_string_draw_box_sweep_counter.sv
// Walks a glyph box in glyph -> row -> column order, column fastest.
module box_sweep_counter
    import glyph_string_draw_pkg::*;
#(
    parameter int GLYPH_W    = DEF_GLYPH_W,
    parameter int GLYPH_H    = DEF_GLYPH_H,
    parameter int NUM_GLYPHS = DEF_NUM_GLYPHS,
    localparam int GLY_W     = cnt_w(NUM_GLYPHS),
    localparam int ROW_W     = cnt_w(GLYPH_H),
    localparam int COL_W     = cnt_w(GLYPH_W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_clr,
    output logic [GLY_W-1:0] o_glyph,
    output logic [ROW_W-1:0] o_row,
    output logic [COL_W-1:0] o_col,
    output logic             o_last
);

    logic [GLY_W-1:0] r_glyph;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic             w_col_end;
    logic             w_row_end;
    logic             w_glyph_end;

    assign w_col_end   = (r_col == COL_W'(GLYPH_W - 1));
    assign w_row_end   = (r_row == ROW_W'(GLYPH_H - 1));
    assign w_glyph_end = (r_glyph == GLY_W'(NUM_GLYPHS - 1));

    always_ff @(posedge clk) begin
        if (!reset || i_clr) begin
            r_glyph <= '0;
            r_row   <= '0;
            r_col   <= '0;
        end else if (i_en) begin
            if (w_col_end) begin
                r_col <= '0;
                if (w_row_end) begin
                    r_row   <= '0;
                    // Wrapping to zero leaves the counter ready for the next sweep.
                    r_glyph <= w_glyph_end ? '0 : r_glyph + GLY_W'(1);
                end else begin
                    r_row <= r_row + ROW_W'(1);
                end
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    assign o_glyph = r_glyph;
    assign o_row   = r_row;
    assign o_col   = r_col;
    assign o_last  = w_col_end && w_row_end && w_glyph_end;

endmodule

// File: rtl/glyph_string_draw.sv
// Renders a string of bitmap glyphs into a pixel-write stream: full-screen clear
// after reset, then per request an erase of the previous box followed by a draw.
module glyph_string_draw
    import glyph_string_draw_pkg::*;
#(
    parameter int GLYPH_W    = DEF_GLYPH_W,
    parameter int GLYPH_H    = DEF_GLYPH_H,
    parameter int NUM_GLYPHS = DEF_NUM_GLYPHS,
    parameter int SCREEN_W   = DEF_SCREEN_W,
    parameter int SCREEN_H   = DEF_SCREEN_H,
    parameter int COLOUR_W   = DEF_COLOUR_W
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   ld,
    input  logic [X_W-1:0]                         x,
    input  logic [Y_W-1:0]                         y,
    input  logic [COLOUR_W-1:0]                    colour_in,
    input  logic [NUM_GLYPHS*GLYPH_W*GLYPH_H-1:0]  glyphs,
    output logic [X_W-1:0]                         x_out,
    output logic [Y_W-1:0]                         y_out,
    output logic [COLOUR_W-1:0]                    colour,
    output logic                                   writeEn,
    output logic                                   busy,
    output logic                                   done
);

    localparam int BITS  = NUM_GLYPHS * GLYPH_W * GLYPH_H;
    localparam int IDX_W = cnt_w(BITS);
    localparam int GLY_W = cnt_w(NUM_GLYPHS);
    localparam int ROW_W = cnt_w(GLYPH_H);
    localparam int COL_W = cnt_w(GLYPH_W);
    localparam int AX_W  = X_W + ADDR_PAD;
    localparam int AY_W  = Y_W + ADDR_PAD;

    state_t              r_state;
    state_t              w_next;
    logic                r_ld_d;
    logic                w_ld_rise;

    logic [X_W-1:0]      r_scr_x;
    logic [Y_W-1:0]      r_scr_y;
    logic                w_scr_last;

    logic [X_W-1:0]      r_org_x;
    logic [Y_W-1:0]      r_org_y;
    logic [X_W-1:0]      r_prev_x;
    logic [Y_W-1:0]      r_prev_y;
    logic [COLOUR_W-1:0] r_fg;
    logic [BITS-1:0]     r_bitmap;

    logic [GLY_W-1:0]    w_glyph;
    logic [ROW_W-1:0]    w_row;
    logic [COL_W-1:0]    w_col;
    logic                w_box_last;
    logic                w_box_en;
    logic                w_box_clr;

    logic [X_W-1:0]      w_base_x;
    logic [Y_W-1:0]      w_base_y;
    logic [AX_W-1:0]     w_px;
    logic [AY_W-1:0]     w_py;
    logic                w_on_screen;
    logic [IDX_W-1:0]    w_lin;
    logic [IDX_W-1:0]    w_idx;
    logic                w_bit;

    logic                w_we_nxt;
    logic [COLOUR_W-1:0] w_colour_nxt;
    logic [X_W-1:0]      w_x_nxt;
    logic [Y_W-1:0]      w_y_nxt;
    logic                w_end_nxt;

    logic [X_W-1:0]      r_x_out;
    logic [Y_W-1:0]      r_y_out;
    logic [COLOUR_W-1:0] r_colour;
    logic                r_we;
    logic                r_busy;
    logic                r_sweep_end;
    logic                r_done;

    assign w_ld_rise = ld & ~r_ld_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RESET: if (w_scr_last) w_next = S_IDLE;
            S_IDLE:  if (w_ld_rise)  w_next = S_CLEAR;
            S_CLEAR: if (w_box_last) w_next = S_DRAW;
            S_DRAW:  if (w_box_last) w_next = S_IDLE;
            default: w_next = S_RESET;
        endcase
    end

    assign w_scr_last = (r_scr_x == X_W'(SCREEN_W - 1)) && (r_scr_y == Y_W'(SCREEN_H - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ld_d  <= 1'b0;
            r_scr_x <= '0;
            r_scr_y <= '0;
        end else begin
            r_ld_d <= ld;
            if (r_state == S_RESET) begin
                if (r_scr_x == X_W'(SCREEN_W - 1)) begin
                    r_scr_x <= '0;
                    r_scr_y <= (r_scr_y == Y_W'(SCREEN_H - 1)) ? '0 : r_scr_y + Y_W'(1);
                end else begin
                    r_scr_x <= r_scr_x + X_W'(1);
                end
            end
        end
    end

    // Request inputs are captured once; later changes cannot disturb a sweep.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_org_x  <= '0;
            r_org_y  <= '0;
            r_prev_x <= '0;
            r_prev_y <= '0;
            r_fg     <= '0;
            r_bitmap <= '0;
        end else begin
            if (r_state == S_IDLE && w_ld_rise) begin
                r_org_x  <= x;
                r_org_y  <= y;
                r_fg     <= colour_in;
                r_bitmap <= glyphs;
            end
            if (r_state == S_DRAW && w_box_last) begin
                r_prev_x <= r_org_x;
                r_prev_y <= r_org_y;
            end
        end
    end

    assign w_box_en  = (r_state == S_CLEAR) || (r_state == S_DRAW);
    assign w_box_clr = (r_state == S_IDLE) || (r_state == S_RESET);

    box_sweep_counter #(
        .GLYPH_W   (GLYPH_W),
        .GLYPH_H   (GLYPH_H),
        .NUM_GLYPHS(NUM_GLYPHS)
    ) u_box (
        .clk    (clk),
        .reset  (reset),
        .i_en   (w_box_en),
        .i_clr  (w_box_clr),
        .o_glyph(w_glyph),
        .o_row  (w_row),
        .o_col  (w_col),
        .o_last (w_box_last)
    );

    assign w_base_x = (r_state == S_DRAW) ? r_org_x : r_prev_x;
    assign w_base_y = (r_state == S_DRAW) ? r_org_y : r_prev_y;

    // Wide addresses so pixels past the screen edge are clipped rather than wrapped.
    assign w_px = AX_W'(w_base_x) + AX_W'(w_glyph) * AX_W'(GLYPH_W) + AX_W'(w_col);
    assign w_py = AY_W'(w_base_y) + AY_W'(w_row);
    assign w_on_screen = (w_px < AX_W'(SCREEN_W)) && (w_py < AY_W'(SCREEN_H));

    // Glyph 0 sits at the MSB end and each glyph is MSB-first row-major,
    // so the sweep position counts down from the top bit.
    assign w_lin = IDX_W'(w_glyph) * IDX_W'(GLYPH_W * GLYPH_H)
                 + IDX_W'(w_row) * IDX_W'(GLYPH_W) + IDX_W'(w_col);
    assign w_idx = IDX_W'(BITS - 1) - w_lin;
    assign w_bit = r_bitmap[w_idx];

    always_comb begin
        w_we_nxt     = 1'b0;
        w_colour_nxt = '0;
        w_x_nxt      = r_x_out;
        w_y_nxt      = r_y_out;
        w_end_nxt    = 1'b0;
        case (r_state)
            S_RESET: begin
                w_we_nxt  = 1'b1;
                w_x_nxt   = r_scr_x;
                w_y_nxt   = r_scr_y;
                w_end_nxt = w_scr_last;
            end
            S_CLEAR: begin
                w_we_nxt = w_on_screen;
                w_x_nxt  = w_px[X_W-1:0];
                w_y_nxt  = w_py[Y_W-1:0];
            end
            S_DRAW: begin
                w_we_nxt     = w_on_screen & w_bit;
                w_colour_nxt = r_fg;
                w_x_nxt      = w_px[X_W-1:0];
                w_y_nxt      = w_py[Y_W-1:0];
                w_end_nxt    = w_box_last;
            end
            default: ;
        endcase
    end

    // busy and done are pipelined to stay aligned with the registered pixel stream.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_x_out     <= '0;
            r_y_out     <= '0;
            r_colour    <= '0;
            r_we        <= 1'b0;
            r_busy      <= 1'b1;
            r_sweep_end <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_x_out     <= w_x_nxt;
            r_y_out     <= w_y_nxt;
            r_colour    <= w_colour_nxt;
            r_we        <= w_we_nxt;
            r_busy      <= (r_state != S_IDLE);
            r_sweep_end <= w_end_nxt;
            r_done      <= r_sweep_end;
        end
    end

    assign x_out   = r_x_out;
    assign y_out   = r_y_out;
    assign colour  = r_colour;
    assign writeEn = r_we;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_glyph_string_draw.sv
// Directed bench for glyph_string_draw: screen clear, draw/erase sequencing,
// bit ordering, clipping, request filtering and mid-sweep reset.
module tb_glyph_string_draw;

    logic         clk;
    logic         reset;
    logic         ld;
    logic [7:0]   x;
    logic [6:0]   y;
    logic [2:0]   colour_in;
    logic [431:0] glyphs;
    logic [7:0]   x_out;
    logic [6:0]   y_out;
    logic [2:0]   colour;
    logic         writeEn;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] pc;
    } wr_t;

    wr_t wq[$];
    int  cap_busy;
    int  cap_done;
    int  cap_first_done;
    int  cap_oob;

    glyph_string_draw #(
        .GLYPH_W(12), .GLYPH_H(12), .NUM_GLYPHS(3),
        .SCREEN_W(160), .SCREEN_H(120), .COLOUR_W(3)
    ) dut (
        .clk(clk), .reset(reset), .ld(ld), .x(x), .y(y),
        .colour_in(colour_in), .glyphs(glyphs),
        .x_out(x_out), .y_out(y_out), .colour(colour),
        .writeEn(writeEn), .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected pixel of the k-th step of a box sweep (glyph, row, column).
    function automatic int box_x(input int ox, input int k);
        return ox + (k / 144) * 12 + (k % 12);
    endfunction

    function automatic int box_y(input int oy, input int k);
        return oy + (k % 144) / 12;
    endfunction

    // Records n cycles of output activity; each sample is taken on the falling edge.
    task automatic capture(input int n);
        wq.delete();
        cap_busy = 0;
        cap_done = 0;
        cap_first_done = 0;
        cap_oob = 0;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (writeEn === 1'b1) begin
                wq.push_back('{x_out, y_out, colour});
                if (x_out >= 8'd160 || y_out >= 7'd120) cap_oob++;
            end
            if (busy === 1'b1) cap_busy++;
            if (done === 1'b1) begin
                cap_done++;
                if (cap_first_done == 0) cap_first_done = i;
            end
        end
    endtask

    task automatic start_draw(input logic [7:0] sx, input logic [6:0] sy,
                              input logic [2:0] sc, input logic [431:0] sg);
        ld = 1'b0;
        @(negedge clk);
        x = sx;
        y = sy;
        colour_in = sc;
        glyphs = sg;
        ld = 1'b1;
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({writeEn, colour, x_out, y_out, busy, done} !== {1'b0, 3'd0, 8'd0, 7'd0, 1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_values: got we=%b c=%0d x=%0d y=%0d busy=%b done=%b, expected 0 0 0 0 1 0",
                     writeEn, colour, x_out, y_out, busy, done);
        end
        reset = 1'b1;
        capture(19210);
        n_checks++;
        if (wq.size() != 19200) begin
            n_errors++;
            $display("FAIL reset_write_count: got %0d expected 19200", wq.size());
        end
        bad = 0;
        for (int k = 0; k < wq.size(); k++)
            if (k >= 19200 || wq[k] !== {8'(k % 160), 7'(k / 160), 3'd0}) bad++;
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL reset_sweep_order: got %0d bad pixels expected 0", bad);
        end
        n_checks++;
        if (cap_done != 1 || cap_first_done != 19201) begin
            n_errors++;
            $display("FAIL reset_done: got count=%0d at=%0d expected 1 at 19201", cap_done, cap_first_done);
        end
        n_checks++;
        if (cap_busy != 19200 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_busy: got %0d cycles, final=%b expected 19200, 0", cap_busy, busy);
        end
    endtask

    task automatic test_first_draw();
        int bad;
        logic [431:0] g;
        g = '0;
        g[431:288] = '1;
        start_draw(8'd10, 7'd20, 3'd5, g);
        capture(900);
        n_checks++;
        if (wq.size() != 576) begin
            n_errors++;
            $display("FAIL draw1_write_count: got %0d expected 576", wq.size());
        end
        bad = 0;
        for (int k = 0; k < wq.size(); k++) begin
            if (k < 432) begin
                if (wq[k] !== {8'(box_x(0, k)), 7'(box_y(0, k)), 3'd0}) bad++;
            end else if (k < 576) begin
                if (wq[k] !== {8'(10 + (k - 432) % 12), 7'(20 + (k - 432) / 12), 3'd5}) bad++;
            end else begin
                bad++;
            end
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL draw1_pixels: got %0d bad writes expected 0", bad);
        end
        n_checks++;
        if (cap_busy != 864 || cap_done != 1 || cap_first_done != 866) begin
            n_errors++;
            $display("FAIL draw1_timing: got busy=%0d done=%0d at=%0d expected 864 1 866",
                     cap_busy, cap_done, cap_first_done);
        end
        n_checks++;
        if ({writeEn, colour, x_out, y_out} !== {1'b0, 3'd0, 8'd45, 7'd31}) begin
            n_errors++;
            $display("FAIL idle_hold: got we=%b c=%0d x=%0d y=%0d expected 0 0 45 31",
                     writeEn, colour, x_out, y_out);
        end
    endtask

    task automatic test_second_draw();
        int bad;
        logic [431:0] g;
        g = '0;
        g[288] = 1'b1;
        g[143] = 1'b1;
        start_draw(8'd50, 7'd40, 3'd3, g);
        fork
            capture(900);
            begin
                repeat (5) @(negedge clk);
                x = 8'd0;
                y = 7'd0;
                glyphs = '1;
                colour_in = 3'd7;
            end
        join
        n_checks++;
        if (wq.size() != 434) begin
            n_errors++;
            $display("FAIL draw2_write_count: got %0d expected 434", wq.size());
        end
        bad = 0;
        for (int k = 0; k < wq.size() && k < 432; k++)
            if (wq[k] !== {8'(box_x(10, k)), 7'(box_y(20, k)), 3'd0}) bad++;
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL draw2_erase_prev_box: got %0d bad writes expected 0", bad);
        end
        if (wq.size() == 434) begin
            n_checks++;
            if (wq[432] !== {8'd61, 7'd51, 3'd3} || wq[433] !== {8'd74, 7'd40, 3'd3}) begin
                n_errors++;
                $display("FAIL draw2_bit_order: got (%0d,%0d,%0d) (%0d,%0d,%0d) expected (61,51,3) (74,40,3)",
                         wq[432].px, wq[432].py, wq[432].pc, wq[433].px, wq[433].py, wq[433].pc);
            end
        end
        n_checks++;
        if (cap_done != 1) begin
            n_errors++;
            $display("FAIL draw2_done: got %0d expected 1", cap_done);
        end
    endtask

    task automatic test_clip();
        int n6;
        int outside;
        start_draw(8'd150, 7'd115, 3'd6, '1);
        capture(900);
        n6 = 0;
        outside = 0;
        foreach (wq[k]) begin
            if (wq[k].pc == 3'd6) begin
                n6++;
                if (wq[k].px < 8'd150 || wq[k].py < 7'd115) outside++;
            end
        end
        n_checks++;
        if (wq.size() != 482 || n6 != 50) begin
            n_errors++;
            $display("FAIL clip_write_count: got total=%0d drawn=%0d expected 482 50", wq.size(), n6);
        end
        n_checks++;
        if (cap_oob != 0 || outside != 0) begin
            n_errors++;
            $display("FAIL clip_bounds: got oob=%0d outside=%0d expected 0 0", cap_oob, outside);
        end
        if (wq.size() == 482) begin
            n_checks++;
            if (wq[432] !== {8'd150, 7'd115, 3'd6} || wq[481] !== {8'd159, 7'd119, 3'd6}) begin
                n_errors++;
                $display("FAIL clip_corners: got (%0d,%0d) (%0d,%0d) expected (150,115) (159,119)",
                         wq[432].px, wq[432].py, wq[481].px, wq[481].py);
            end
        end
        n_checks++;
        if (cap_busy != 864 || cap_done != 1) begin
            n_errors++;
            $display("FAIL clip_timing: got busy=%0d done=%0d expected 864 1", cap_busy, cap_done);
        end
    endtask

    task automatic test_ld_filter();
        logic [431:0] g;
        g = '0;
        g[431:288] = '1;
        start_draw(8'd20, 7'd30, 3'd2, g);
        capture(1000);
        n_checks++;
        if (wq.size() != 194 || cap_done != 1 || cap_busy != 864) begin
            n_errors++;
            $display("FAIL ld_held: got writes=%0d done=%0d busy=%0d expected 194 1 864",
                     wq.size(), cap_done, cap_busy);
        end
        start_draw(8'd60, 7'd60, 3'd1, g);
        fork
            capture(1000);
            begin
                repeat (600) @(negedge clk);
                ld = 1'b0;
                @(negedge clk);
                ld = 1'b1;
                @(negedge clk);
                ld = 1'b0;
            end
        join
        n_checks++;
        if (wq.size() != 576 || cap_done != 1 || cap_busy != 864) begin
            n_errors++;
            $display("FAIL ld_pulse_while_busy: got writes=%0d done=%0d busy=%0d expected 576 1 864",
                     wq.size(), cap_done, cap_busy);
        end
    endtask

    task automatic test_mid_reset();
        int bad;
        start_draw(8'd0, 7'd0, 3'd4, '1);
        repeat (533) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL midreset_pre_busy: got %b expected 1", busy);
        end
        reset = 1'b0;
        ld = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({writeEn, busy, done, x_out, y_out} !== {1'b0, 1'b1, 1'b0, 8'd0, 7'd0}) begin
            n_errors++;
            $display("FAIL midreset_values: got we=%b busy=%b done=%b x=%0d y=%0d expected 0 1 0 0 0",
                     writeEn, busy, done, x_out, y_out);
        end
        reset = 1'b1;
        capture(19210);
        bad = 0;
        for (int k = 0; k < wq.size(); k++)
            if (k >= 19200 || wq[k] !== {8'(k % 160), 7'(k / 160), 3'd0}) bad++;
        n_checks++;
        if (wq.size() != 19200 || bad != 0) begin
            n_errors++;
            $display("FAIL midreset_clear: got writes=%0d bad=%0d expected 19200 0", wq.size(), bad);
        end
        n_checks++;
        if (cap_done != 1 || cap_first_done != 19201) begin
            n_errors++;
            $display("FAIL midreset_done: got count=%0d at=%0d expected 1 at 19201", cap_done, cap_first_done);
        end
    endtask

    initial begin
        reset = 1'b0;
        ld = 1'b0;
        x = '0;
        y = '0;
        colour_in = '0;
        glyphs = '0;
        test_reset();
        test_first_draw();
        test_second_draw();
        test_clip();
        test_ld_filter();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/glyph_string_draw.md
GLYPH_STRING_DRAW -- requirements
Module: glyph_string_draw

Interface
REQ-001 SHALL expose parameters: GLYPH_W, 12, glyph width in pixels; GLYPH_H, 12, glyph height; NUM_GLYPHS, 3, glyphs per string; SCREEN_W, 160, pixels per line; SCREEN_H, 120, lines; COLOUR_W, 3, colour bits.
REQ-002 SHALL expose ports: clk input 1 clock; reset input 1 synchronous active-low reset; ld input 1 draw request (level, edge-detected); x input 8 string origin column; y input 7 string origin row; colour_in input COLOUR_W foreground colour; glyphs input NUM_GLYPHS*GLYPH_W*GLYPH_H packed bitmaps; x_out output 8 pixel column; y_out output 7 pixel row; colour output COLOUR_W pixel colour; writeEn output 1 pixel write strobe; busy output 1 sweep in progress; done output 1 one-cycle completion pulse.

Function
REQ-003 SHALL implement states S_RESET, S_IDLE, S_CLEAR, S_DRAW.
REQ-004 S_RESET SHALL sweep all SCREEN_W*SCREEN_H pixels row-major, colour 0, writeEn 1, one pixel per cycle, then go to S_IDLE with done pulsed for one cycle.
REQ-005 In S_IDLE, a rising edge of ld (ld high, previous-cycle ld low) SHALL latch x, y, colour_in, glyphs into a working register and enter S_CLEAR next cycle; ld held high SHALL NOT retrigger.
REQ-006 S_CLEAR SHALL write colour 0 to every pixel of the NUM_GLYPHS*GLYPH_W by GLYPH_H box at the previously drawn origin (reset value of previous origin: 0,0), then enter S_DRAW.
REQ-007 S_DRAW SHALL visit every pixel of the box at the latched origin; writeEn SHALL equal the glyph bit, colour SHALL equal latched colour; zero bits are transparent (writeEn 0).
REQ-008 Glyph bit order SHALL be: glyph g occupies packed field g (glyph 0 at MSB end); within a glyph, MSB is top-left, row-major.
REQ-009 Pixel address SHALL be x + g*GLYPH_W + col, y + row, computed at least 2 bits wider than the coordinate outputs; any pixel with column >= SCREEN_W or row >= SCREEN_H SHALL have writeEn 0 (clipping, no wrap).
REQ-010 Sweep order SHALL be glyph, then row, then column (column fastest); each sweep SHALL take exactly NUM_GLYPHS*GLYPH_W*GLYPH_H cycles with no early termination on all-zero bitmaps.
REQ-011 x_out, y_out, colour, writeEn SHALL be registered; output lags the internal counter by one cycle.
REQ-012 On S_DRAW completion, the latched origin SHALL become the previous origin, done SHALL pulse one cycle, state returns to S_IDLE.
REQ-013 busy SHALL be 1 in S_RESET, S_CLEAR, S_DRAW; 0 in S_IDLE.
REQ-014 ld edges while busy SHALL be ignored (not queued); input changes to x, y, colour_in, glyphs while busy SHALL NOT affect the sweep.
REQ-015 In S_IDLE writeEn SHALL be 0, x_out/y_out hold last value, colour 0.

Reset
REQ-016 reset low at any clk edge, including mid-sweep, SHALL force S_RESET and restart the full-screen clear from pixel (0,0).
REQ-017 Reset values: writeEn 0, colour 0, x_out 0, y_out 0, busy 1, done 0, previous origin (0,0), counters 0, ld edge register 0.

Structure
REQ-018 A shared package SHALL hold the state encoding and default geometry constants (12, 12, 3, 160, 120, 3).
REQ-019 A sub-module box_sweep_counter SHALL generate (glyph, row, col) indices with enable, clear, and last-pixel flag; reused by S_CLEAR and S_DRAW; S_RESET uses a separate screen counter.

Verification
REQ-020 Reset pulse -> 19200 consecutive writeEn=1 cycles, colour 0, last pixel (159,119), then done pulse, busy 0.
REQ-021 ld rise, x=10, y=20, glyph0 all ones, others zero, colour 5 -> 432 clear cycles at (0,0) box, then 144 writes colour 5 covering (10..21, 20..31); 288 cycles writeEn 0; done pulse.
REQ-022 Second ld rise at x=50, y=40 -> clear sweep covers box at (10,20) (36x12), draw at (50,40).
REQ-023 x=150, y=115, all bitmaps ones -> writes only for columns 150..159, rows 115..119; no write with x_out >= 160 or y_out >= 120.
REQ-024 ld held high 1000 cycles and ld pulsed during S_DRAW -> exactly one clear+draw sequence, one done.
REQ-025 reset asserted at cycle 100 of S_DRAW -> next cycle begins full-screen clear at (0,0), busy 1, no done until clear completes.
